// File: rtl/clock_pkg.sv
// ============================================================================
// clock_pkg : shared mode encodings, field limits and ring-step helpers
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

package clock_pkg;

  typedef enum logic [2:0] {
    CLOCK  = 3'd0,
    T_HOUR = 3'd1,
    T_MIN  = 3'd2,
    A_HOUR = 3'd3,
    A_MIN  = 3'd4
  } mode_e;

  localparam int unsigned HOUR_MAX   = 23;
  localparam int unsigned MIN_MAX    = 59;
  localparam int unsigned HOUR_W     = 5;
  localparam int unsigned MIN_W      = 6;
  localparam int unsigned RING_CNT_W = 7;

  // The four set-up modes form a ring; CLOCK is never part of it.
  function automatic mode_e step_fwd(input mode_e m);
    case (m)
      T_HOUR:  step_fwd = T_MIN;
      T_MIN:   step_fwd = A_HOUR;
      A_HOUR:  step_fwd = A_MIN;
      default: step_fwd = T_HOUR;
    endcase
  endfunction

  function automatic mode_e step_back(input mode_e m);
    case (m)
      T_HOUR:  step_back = A_MIN;
      T_MIN:   step_back = T_HOUR;
      A_HOUR:  step_back = T_MIN;
      default: step_back = A_HOUR;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mod_updown_counter.sv
// ============================================================================
// mod_updown_counter : registered modulo-(MAX+1) counter, wraps both ways
// Rev 1.0            : initial release
// ============================================================================
`default_nettype none

module mod_updown_counter #(
  parameter int unsigned MAX     = 59,
  parameter int unsigned W       = 6,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] value_o
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc_i && !dec_i) begin
      value_d = (value_q == W'(MAX)) ? '0 : value_q + W'(1);
    end else if (dec_i && !inc_i) begin
      value_d = (value_q == '0) ? W'(MAX) : value_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= W'(RST_VAL);
    else        value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

`default_nettype wire

// File: rtl/alarm_controller.sv
// ============================================================================
// alarm_controller : mode sequencer, alarm registers and ring scheduler
// Optional snooze feature enabled by defining ALARM_SNOOZE_EN.
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module alarm_controller
  import clock_pkg::*;
#(
  parameter int unsigned RING_SEC       = 60,
  parameter int unsigned ALARM_RST_HOUR = 7,
  parameter int unsigned ALARM_RST_MIN  = 0
`ifdef ALARM_SNOOZE_EN
  , parameter int unsigned SNOOZE_SEC   = 300
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_1hz,
  input  logic              btn_c,
  input  logic              btn_u,
  input  logic              btn_d,
  input  logic              btn_l,
  input  logic              btn_r,
  input  logic [HOUR_W-1:0] time_hour,
  input  logic [MIN_W-1:0]  time_min,
  input  logic [MIN_W-1:0]  time_sec,
  output logic [2:0]        mode,
  output logic              enable_clock,
  output logic              t_hour_inc,
  output logic              t_hour_dec,
  output logic              t_min_inc,
  output logic              t_min_dec,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic [MIN_W-1:0]  alarm_min,
  output logic              alarm_armed,
  output logic              ringing,
  output logic              disp_sel,
  output logic              blink
);

  mode_e                 state_q, state_d;
  logic                  armed_q, armed_d;
  logic                  ringing_q, ringing_d;
  logic                  blink_q, blink_d;
  logic                  en_clk_q, en_clk_d;
  logic                  disp_sel_q, disp_sel_d;
  logic [3:0]            cmd_q, cmd_d;   // {hour_inc, hour_dec, min_inc, min_dec}
  logic [RING_CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic                  ah_inc, ah_dec, am_inc, am_dec;

  logic [4:0] btns;
  logic       valid, press, silence, match;

`ifdef ALARM_SNOOZE_EN
  localparam int unsigned SNZ_W = $clog2(SNOOZE_SEC + 1);
  logic             snoozing_q, snoozing_d;
  logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
`endif

  assign btns  = {btn_c, btn_u, btn_d, btn_l, btn_r};
  assign valid = $onehot(btns);
  // A valid press while ringing only silences; otherwise it drives the FSM.
  assign press   = valid && !ringing_q;
  assign silence = valid && ringing_q;
  assign match   = (state_q == CLOCK) && armed_q && tick_1hz && !ringing_q &&
                   (time_sec == '0) && (time_hour == alarm_hour) &&
                   (time_min == alarm_min);

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    ringing_d  = ringing_q;
    ring_cnt_d = ring_cnt_q;
    blink_d    = blink_q ^ tick_1hz;
    cmd_d      = 4'b0000;
    ah_inc     = 1'b0;
    ah_dec     = 1'b0;
    am_inc     = 1'b0;
    am_dec     = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snoozing_d = snoozing_q;
    snz_cnt_d  = snz_cnt_q;
`endif

    if (silence) begin
      ringing_d  = 1'b0;
      ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
      if (btn_u) begin
        snoozing_d = 1'b1;
        snz_cnt_d  = SNZ_W'(SNOOZE_SEC);
      end
`endif
    end else if (ringing_q && tick_1hz) begin
      if (ring_cnt_q == RING_CNT_W'(RING_SEC - 1)) begin
        ringing_d  = 1'b0;
        ring_cnt_d = '0;
      end else begin
        ring_cnt_d = ring_cnt_q + RING_CNT_W'(1);
      end
    end

`ifdef ALARM_SNOOZE_EN
    // Any press cancels a pending snooze; presses are the only way out of CLOCK.
    if (snoozing_q) begin
      if (press) begin
        snoozing_d = 1'b0;
      end else if (tick_1hz) begin
        if (snz_cnt_q <= SNZ_W'(1)) begin
          snoozing_d = 1'b0;
          snz_cnt_d  = '0;
          ringing_d  = 1'b1;
          ring_cnt_d = '0;
        end else begin
          snz_cnt_d = snz_cnt_q - SNZ_W'(1);
        end
      end
    end
`endif

    if (press) begin
      if (state_q == CLOCK) begin
        if (btn_c)      state_d = T_HOUR;
        else if (btn_d) armed_d = !armed_q;
      end else if (btn_c) begin
        state_d = CLOCK;
      end else if (btn_r) begin
        state_d = step_fwd(state_q);
      end else if (btn_l) begin
        state_d = step_back(state_q);
      end else begin
        case (state_q)
          T_HOUR:  cmd_d = {btn_u, btn_d, 2'b00};
          T_MIN:   cmd_d = {2'b00, btn_u, btn_d};
          A_HOUR:  begin ah_inc = btn_u; ah_dec = btn_d; end
          A_MIN:   begin am_inc = btn_u; am_dec = btn_d; end
          default: ;
        endcase
      end
    end

    if (match) begin
      ringing_d  = 1'b1;
      ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
      snoozing_d = 1'b0;
`endif
    end

    en_clk_d   = (state_d == CLOCK);
    disp_sel_d = (state_d == A_HOUR) || (state_d == A_MIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= CLOCK;
      armed_q    <= 1'b0;
      ringing_q  <= 1'b0;
      ring_cnt_q <= '0;
      blink_q    <= 1'b0;
      en_clk_q   <= 1'b1;
      disp_sel_q <= 1'b0;
      cmd_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      ringing_q  <= ringing_d;
      ring_cnt_q <= ring_cnt_d;
      blink_q    <= blink_d;
      en_clk_q   <= en_clk_d;
      disp_sel_q <= disp_sel_d;
      cmd_q      <= cmd_d;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snoozing_q <= 1'b0;
      snz_cnt_q  <= '0;
    end else begin
      snoozing_q <= snoozing_d;
      snz_cnt_q  <= snz_cnt_d;
    end
  end
`endif

  mod_updown_counter #(
    .MAX     (HOUR_MAX),
    .W       (HOUR_W),
    .RST_VAL (ALARM_RST_HOUR)
  ) u_alarm_hour (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (ah_inc),
    .dec_i   (ah_dec),
    .value_o (alarm_hour)
  );

  mod_updown_counter #(
    .MAX     (MIN_MAX),
    .W       (MIN_W),
    .RST_VAL (ALARM_RST_MIN)
  ) u_alarm_min (
    .clk     (clk),
    .rst_n   (rst),
    .inc_i   (am_inc),
    .dec_i   (am_dec),
    .value_o (alarm_min)
  );

  assign mode         = state_q;
  assign enable_clock = en_clk_q;
  assign t_hour_inc   = cmd_q[3];
  assign t_hour_dec   = cmd_q[2];
  assign t_min_inc    = cmd_q[1];
  assign t_min_dec    = cmd_q[0];
  assign alarm_armed  = armed_q;
  assign ringing      = ringing_q;
  assign disp_sel     = disp_sel_q;
  assign blink        = blink_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_controller.sv
// ============================================================================
// tb_alarm_controller : directed stimulus, cycle-by-cycle behavioural model
// Rev 1.0             : initial release
// ============================================================================
`default_nettype none

module tb_alarm_controller;

  localparam int RING = 60;
  localparam int SNZ  = 3;
  localparam logic [4:0] BC = 5'b10000, BU = 5'b01000, BD = 5'b00100,
                         BL = 5'b00010, BR = 5'b00001, BN = 5'b00000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       bc = 1'b0, bu = 1'b0, bd = 1'b0, bl = 1'b0, br = 1'b0;
  logic [4:0] t_hour = '0;
  logic [5:0] t_min = '0, t_sec = '0;

  logic [2:0] mode;
  logic       enable_clock, t_hour_inc, t_hour_dec, t_min_inc, t_min_dec;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_armed, ringing, disp_sel, blink;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alarm_controller #(
    .RING_SEC       (RING),
    .ALARM_RST_HOUR (7),
    .ALARM_RST_MIN  (0)
`ifdef ALARM_SNOOZE_EN
    , .SNOOZE_SEC   (SNZ)
`endif
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick),
    .btn_c        (bc),
    .btn_u        (bu),
    .btn_d        (bd),
    .btn_l        (bl),
    .btn_r        (br),
    .time_hour    (t_hour),
    .time_min     (t_min),
    .time_sec     (t_sec),
    .mode         (mode),
    .enable_clock (enable_clock),
    .t_hour_inc   (t_hour_inc),
    .t_hour_dec   (t_hour_dec),
    .t_min_inc    (t_min_inc),
    .t_min_dec    (t_min_dec),
    .alarm_hour   (alarm_hour),
    .alarm_min    (alarm_min),
    .alarm_armed  (alarm_armed),
    .ringing      (ringing),
    .disp_sel     (disp_sel),
    .blink        (blink)
  );

  // Behavioural model: mode as a plain integer 0..4, alarm fields as integers.
  int m_mode, m_armed, m_ah, m_am, m_ring, m_rt, m_blink;
  int m_hi, m_hd, m_mi, m_md;
`ifdef ALARM_SNOOZE_EN
  int m_sn, m_snc;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_armed = 0; m_ah = 7; m_am = 0; m_ring = 0; m_rt = 0;
    m_blink = 0; m_hi = 0; m_hd = 0; m_mi = 0; m_md = 0;
`ifdef ALARM_SNOOZE_EN
    m_sn = 0; m_snc = 0;
`endif
  endtask

  task automatic model_step();
    int nb;
    bit v, hit;
    nb  = int'(bc) + int'(bu) + int'(bd) + int'(bl) + int'(br);
    v   = (nb == 1);
    hit = (m_mode == 0) && (m_armed != 0) && tick && (t_sec == 0) &&
          (int'(t_hour) == m_ah) && (int'(t_min) == m_am) && (m_ring == 0);
    m_hi = 0; m_hd = 0; m_mi = 0; m_md = 0;
    if (m_ring != 0) begin
      if (v) begin
        m_ring = 0; m_rt = 0;
`ifdef ALARM_SNOOZE_EN
        if (bu) begin m_sn = 1; m_snc = SNZ; end
`endif
      end else if (tick) begin
        m_rt++;
        if (m_rt == RING) begin m_ring = 0; m_rt = 0; end
      end
    end else begin
`ifdef ALARM_SNOOZE_EN
      if (m_sn != 0) begin
        if (v) m_sn = 0;
        else if (tick) begin
          m_snc--;
          if (m_snc == 0) begin m_sn = 0; m_ring = 1; m_rt = 0; end
        end
      end
`endif
      if (v) begin
        if (m_mode == 0) begin
          if (bc) m_mode = 1;
          else if (bd) m_armed = (m_armed == 0) ? 1 : 0;
        end else if (bc) m_mode = 0;
        else if (br) m_mode = m_mode % 4 + 1;
        else if (bl) m_mode = (m_mode + 2) % 4 + 1;
        else if (bu) begin
          if (m_mode == 1) m_hi = 1;
          if (m_mode == 2) m_mi = 1;
          if (m_mode == 3) m_ah = (m_ah + 1) % 24;
          if (m_mode == 4) m_am = (m_am + 1) % 60;
        end else if (bd) begin
          if (m_mode == 1) m_hd = 1;
          if (m_mode == 2) m_md = 1;
          if (m_mode == 3) m_ah = (m_ah + 23) % 24;
          if (m_mode == 4) m_am = (m_am + 59) % 60;
        end
      end
    end
    if (hit) begin
      m_ring = 1; m_rt = 0;
`ifdef ALARM_SNOOZE_EN
      m_sn = 0;
`endif
    end
    if (tick) m_blink = 1 - m_blink;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("mode",       mode,         m_mode);
      chk("enable",     enable_clock, (m_mode == 0) ? 1 : 0);
      chk("disp_sel",   disp_sel,     (m_mode >= 3) ? 1 : 0);
      chk("t_hour_inc", t_hour_inc,   m_hi);
      chk("t_hour_dec", t_hour_dec,   m_hd);
      chk("t_min_inc",  t_min_inc,    m_mi);
      chk("t_min_dec",  t_min_dec,    m_md);
      chk("alarm_hour", alarm_hour,   m_ah);
      chk("alarm_min",  alarm_min,    m_am);
      chk("armed",      alarm_armed,  m_armed);
      chk("ringing",    ringing,      m_ring);
      chk("blink",      blink,        m_blink);
    end
  end

  // One clock cycle with the given tick and buttons {c,u,d,l,r}.
  task automatic cyc(input bit t, input logic [4:0] b);
    {bc, bu, bd, bl, br} = b;
    tick = t;
    @(posedge clk);
    #1;
    {bc, bu, bd, bl, br} = 5'b00000;
    tick = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mode", mode, 0);
    chk("rst_en", enable_clock, 1);
    chk("rst_ahour", alarm_hour, 7);
    chk("rst_amin", alarm_min, 0);
    chk("rst_armed", alarm_armed, 0);
    chk("rst_ring", ringing, 0);
    rst = 1'b1;
    cyc(0, BN);

    cyc(0, BC); chk("c1_mode", mode, 1); chk("c1_en", enable_clock, 0);
    cyc(0, BC); chk("c2_mode", mode, 0); chk("c2_en", enable_clock, 1);

    cyc(0, BC); cyc(0, BR); chk("tmin_mode", mode, 2);
    cyc(0, BU); chk("minc_hi", t_min_inc, 1);
    cyc(0, BN); chk("minc_lo", t_min_inc, 0);
    cyc(0, BU | BD); chk("dual_inc", t_min_inc, 0); chk("dual_dec", t_min_dec, 0);
    chk("dual_mode", mode, 2);

    cyc(0, BR); chk("ah_mode", mode, 3); chk("ah_disp", disp_sel, 1);
    repeat (8) cyc(0, BD);
    chk("ah_wrap_dn", alarm_hour, 23);
    cyc(0, BU); chk("ah_wrap_up", alarm_hour, 0);
    repeat (7) cyc(0, BU);
    chk("ah_back7", alarm_hour, 7);
    cyc(0, BR); chk("am_mode", mode, 4);
    cyc(0, BD); chk("am_wrap_dn", alarm_min, 59);
    cyc(0, BU); chk("am_wrap_up", alarm_min, 0);
    cyc(0, BL); chk("l1_mode", mode, 3);
    cyc(0, BL); cyc(0, BL); chk("l3_mode", mode, 1);
    cyc(0, BL); chk("l4_mode", mode, 4);
    cyc(0, BC); chk("back_clk", mode, 0); chk("back_disp", disp_sel, 0);

    cyc(0, BD); chk("arm", alarm_armed, 1);

    t_hour = 5'd7; t_min = 6'd0; t_sec = 6'd0;
    cyc(1, BN); chk("ring_on", ringing, 1);
    t_sec = 6'd1;
    repeat (59) begin cyc(1, BN); cyc(0, BN); end
    chk("ring_59", ringing, 1);
    cyc(1, BN); chk("ring_auto_off", ringing, 0);

    t_sec = 6'd0; cyc(1, BN); chk("ring2_on", ringing, 1);
    t_sec = 6'd1; cyc(0, BC);
    chk("silence_c", ringing, 0); chk("silence_mode", mode, 0);

    t_sec = 6'd0; cyc(1, BN); t_sec = 6'd1;
    cyc(0, BD); chk("silence_d", ringing, 0); chk("silence_armed", alarm_armed, 1);

    cyc(0, BC); t_sec = 6'd0; cyc(1, BN); chk("missed", ringing, 0);
    t_sec = 6'd1; cyc(0, BC);

    t_sec = 6'd0; cyc(1, BC);
    chk("match_press_ring", ringing, 1); chk("match_press_mode", mode, 1);
    t_sec = 6'd1; cyc(0, BC);
    chk("consume_ring", ringing, 0); chk("consume_mode", mode, 1);
    cyc(0, BC);

    t_sec = 6'd0; cyc(1, BN); t_sec = 6'd1;
    repeat (59) cyc(1, BN);
    cyc(1, BR); chk("timeout_press_ring", ringing, 0); chk("timeout_press_mode", mode, 0);

`ifdef ALARM_SNOOZE_EN
    t_sec = 6'd0; cyc(1, BN); t_sec = 6'd1;
    cyc(0, BU); chk("snooze_off", ringing, 0);
    cyc(1, BN); cyc(1, BN); chk("snooze_2", ringing, 0);
    cyc(1, BN); chk("snooze_ring", ringing, 1);
    cyc(0, BC);
`endif

    cyc(0, BD); chk("disarm", alarm_armed, 0);
    t_sec = 6'd0; cyc(1, BN); chk("disarmed_noring", ringing, 0);
    t_sec = 6'd1;

    cyc(0, BC); cyc(0, BR); cyc(0, BR); cyc(0, BU);
    chk("pre_rst_ah", alarm_hour, 8);
    #2 rst = 1'b0;
    #1;
    chk("arst_mode", mode, 0);
    chk("arst_ah", alarm_hour, 7);
    chk("arst_en", enable_clock, 1);
    @(posedge clk); #1 rst = 1'b1;
    cyc(0, BN); cyc(0, BN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
